// File: rtl/gpu_mem_dma.sv
// gpu_mem_dma: copies SIZE words from CPU data RAM, starting at a latched
// base address, into GPU object memory entries 0..SIZE-1 once per start pulse.
//
// state  | meaning
// IDLE   | waiting for start; no RAM request
// COPY   | requesting RAM port, issuing one read per granted cycle
// DRAIN  | last read data returning, final GPU write this cycle
// FINISH | one-cycle done pulse, then back to IDLE
module gpu_mem_dma #(
    parameter int ADDR_WIDTH     = 6,
    parameter int SIZE           = 64,
    parameter int DATA_WIDTH     = 16,
    parameter int RAM_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
    output logic                      mem_req,
    input  logic                      mem_grant,
    output logic [RAM_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     mem_dout,
    output logic                      gpu_we,
    output logic [ADDR_WIDTH-1:0]     gpu_addr,
    output logic [DATA_WIDTH-1:0]     gpu_din,
    output logic                      busy,
    output logic                      done
);

    localparam int RD_W = ADDR_WIDTH + 1;
    localparam logic [RD_W-1:0]       LAST_IDX = RD_W'(SIZE - 1);
    localparam logic [RD_W-1:0]       RD_ONE   = RD_W'(1);
    localparam logic [ADDR_WIDTH-1:0] WR_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, COPY, DRAIN, FINISH} state_t;

    state_t                    state, state_nxt;
    logic [RAM_ADDR_WIDTH-1:0] base_q;
    logic [RD_W-1:0]           rd_idx;
    logic [ADDR_WIDTH-1:0]     wr_idx;
    logic                      rd_valid;
    logic                      issue;

    // A read issues whenever we are requesting and the arbiter grants
    assign issue = (state == COPY) && mem_grant;

    // Write port is driven straight from the returning read data
    assign gpu_we   = rd_valid;
    assign gpu_addr = wr_idx;
    assign gpu_din  = mem_dout;

    // State register, counters and read-valid pipeline bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            rd_idx   <= '0;
            wr_idx   <= '0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= issue;
            if ((state == IDLE) && start) begin
                base_q <= base_addr;
                rd_idx <= '0;
                wr_idx <= '0;
            end else begin
                if (issue)    rd_idx <= rd_idx + RD_ONE;
                if (rd_valid) wr_idx <= wr_idx + WR_ONE;
            end
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        mem_rd_addr = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = COPY;
            end
            COPY: begin
                mem_req     = 1'b1;
                busy        = 1'b1;
                mem_rd_addr = base_q + RAM_ADDR_WIDTH'(rd_idx);
                if (issue && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpu_mem_dma.sv
// Bench for gpu_mem_dma: models the CPU RAM (1-cycle read) and GPU memory,
// scores every GPU write against an expected queue filled at start time.
module tb_gpu_mem_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        mem_req;
    logic        mem_grant = 1'b0;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_dout = '0;
    logic        gpu_we;
    logic [5:0]  gpu_addr;
    logic [15:0] gpu_din;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] gpu_mem [64];
    logic [21:0] exp_q [$];
    logic [15:0] exp_rd_base = '0;
    logic [15:0] exp_rd_cnt  = '0;

    gpu_mem_dma #(
        .ADDR_WIDTH(6), .SIZE(64), .DATA_WIDTH(16), .RAM_ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .mem_req(mem_req), .mem_grant(mem_grant), .mem_rd_addr(mem_rd_addr),
        .mem_dout(mem_dout), .gpu_we(gpu_we), .gpu_addr(gpu_addr),
        .gpu_din(gpu_din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_f(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // CPU data RAM: synchronous read, data valid the cycle after issue
    always @(posedge clk) begin
        if (mem_req && mem_grant) mem_dout <= ram_f(mem_rd_addr);
    end

    // GPU memory: synchronous write
    always @(posedge clk) begin
        if (gpu_we) gpu_mem[gpu_addr] <= gpu_din;
    end

    // Scoreboard monitor: read addresses and write ordering/data
    always @(negedge clk) begin
        logic [15:0] ea;
        logic [21:0] e;
        if (mem_req && mem_grant) begin
            ea = exp_rd_base + exp_rd_cnt;
            n_tests++;
            if (mem_rd_addr !== ea) begin
                n_fail++;
                $display("FAIL rd_addr: got %h expected %h", mem_rd_addr, ea);
            end
            exp_rd_cnt = exp_rd_cnt + 16'd1;
        end
        if (gpu_we) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_write: got addr %0d data %h expected no write", gpu_addr, gpu_din);
            end else begin
                e = exp_q.pop_front();
                if ({gpu_addr, gpu_din} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                             gpu_addr, gpu_din, e[21:16], e[15:0]);
                end
            end
            n_tests++;
            if (done || !busy) begin
                n_fail++;
                $display("FAIL we_state: got done=%b busy=%b with gpu_we expected done=0 busy=1", done, busy);
            end
        end
    end

    // Drives one transfer; cycle 0 is the start cycle. Returns observed timing.
    task automatic run_copy(input logic [15:0] base, input bit stall,
                            input int glitch_cyc, input int reset_cyc,
                            output int lat, output int ndone, output int nwe);
        int cyc;
        lat = -1; ndone = 0; nwe = 0;
        @(posedge clk); #1;
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back({i[5:0], ram_f(base + 16'(i))});
        exp_rd_base = base;
        exp_rd_cnt  = '0;
        start = 1'b1; base_addr = base; mem_grant = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        for (int k = 0; k < 300; k++) begin
            mem_grant = stall ? ((cyc > 64) || (cyc % 2 == 1)) : 1'b1;
            if (cyc == glitch_cyc) begin start = 1'b1; base_addr = 16'h3000; end
            else start = 1'b0;
            reset = (cyc == reset_cyc);
            @(negedge clk);
            if (done) begin ndone++; if (lat < 0) lat = cyc; end
            if (gpu_we) nwe++;
            if (cyc == reset_cyc + 1) break;
            if (lat >= 0 && cyc >= lat + 12) break;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if ({mem_req, mem_rd_addr, gpu_we, gpu_addr, busy, done} !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_idle: got req=%b rd=%h we=%b ga=%0d busy=%b done=%b expected all 0",
                         mem_req, mem_rd_addr, gpu_we, gpu_addr, busy, done);
            end
        end
    endtask

    task automatic test_full_copy();
        int lat, nd, nw;
        run_copy(16'h0100, 1'b0, -1, -1, lat, nd, nw);
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL full_latency: got %0d expected 66", lat); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d expected 1", nd); end
        n_tests++; if (nw !== 64) begin n_fail++; $display("FAIL full_we_cnt: got %0d expected 64", nw); end
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL full_missing: got %0d left expected 0", exp_q.size()); end
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (gpu_mem[i] !== ram_f(16'h0100 + 16'(i))) begin
                n_fail++;
                $display("FAIL full_mem[%0d]: got %h expected %h", i, gpu_mem[i], ram_f(16'h0100 + 16'(i)));
            end
        end
    endtask

    task automatic test_stalled();
        int lat, nd, nw;
        run_copy(16'h0100, 1'b1, -1, -1, lat, nd, nw);
        n_tests++; if (lat !== 98) begin n_fail++; $display("FAIL stall_latency: got %0d expected 98", lat); end
        n_tests++; if (nw !== 64) begin n_fail++; $display("FAIL stall_we_cnt: got %0d expected 64", nw); end
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stall_missing: got %0d left expected 0", exp_q.size()); end
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (gpu_mem[i] !== ram_f(16'h0100 + 16'(i))) begin
                n_fail++;
                $display("FAIL stall_mem[%0d]: got %h expected %h", i, gpu_mem[i], ram_f(16'h0100 + 16'(i)));
            end
        end
    endtask

    task automatic test_wrap();
        int lat, nd, nw;
        run_copy(16'hFFF0, 1'b0, -1, -1, lat, nd, nw);
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 66", lat); end
        n_tests++; if (gpu_mem[16] !== 16'hA5A5) begin n_fail++; $display("FAIL wrap_mem16: got %h expected a5a5", gpu_mem[16]); end
        n_tests++; if (gpu_mem[15] !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_mem15: got %h expected 5a5a", gpu_mem[15]); end
        n_tests++; if (gpu_mem[63] !== 16'hA58A) begin n_fail++; $display("FAIL wrap_mem63: got %h expected a58a", gpu_mem[63]); end
    endtask

    task automatic test_start_ignored();
        int lat, nd, nw;
        run_copy(16'h0500, 1'b0, 10, -1, lat, nd, nw);
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL ign_latency: got %0d expected 66", lat); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL ign_done_cnt: got %0d expected 1", nd); end
        n_tests++; if (busy !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL ign_idle_after: got busy=%b req=%b expected 0 0", busy, mem_req); end
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (gpu_mem[i] !== ram_f(16'h0500 + 16'(i))) begin
                n_fail++;
                $display("FAIL ign_mem[%0d]: got %h expected %h", i, gpu_mem[i], ram_f(16'h0500 + 16'(i)));
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd, nw;
        for (int i = 0; i < 64; i++) gpu_mem[i] = 16'hDEAD;
        run_copy(16'h2000, 1'b0, -1, 19, lat, nd, nw);
        n_tests++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || gpu_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got busy=%b req=%b we=%b expected 0 0 0", busy, mem_req, gpu_we);
        end
        n_tests++; if (nw !== 18) begin n_fail++; $display("FAIL rst_mid_we_cnt: got %0d expected 18", nw); end
        exp_q.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (gpu_mem[i] !== ((i < 18) ? ram_f(16'h2000 + 16'(i)) : 16'hDEAD)) begin
                n_fail++;
                $display("FAIL rst_mid_mem[%0d]: got %h expected %h", i, gpu_mem[i],
                         (i < 18) ? ram_f(16'h2000 + 16'(i)) : 16'hDEAD);
            end
        end
        run_copy(16'h0040, 1'b0, -1, -1, lat, nd, nw);
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL rst_fresh_latency: got %0d expected 66", lat); end
        n_tests++; if (nw !== 64) begin n_fail++; $display("FAIL rst_fresh_we_cnt: got %0d expected 64", nw); end
        for (int i = 0; i < 64; i++) begin
            n_tests++;
            if (gpu_mem[i] !== ram_f(16'h0040 + 16'(i))) begin
                n_fail++;
                $display("FAIL rst_fresh_mem[%0d]: got %h expected %h", i, gpu_mem[i], ram_f(16'h0040 + 16'(i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_copy();
        test_stalled();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
